// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to a fixed-latency instruction
// memory and buffers the returned instructions for an in-order valid/ready consumer.
module fetch_queue #(
   parameter int unsigned LEN_MEM_ADDR     = 32,
   parameter int unsigned LEN_INST         = 32,
   parameter int unsigned LEN_MEMISTR_ADDR = 15,
   parameter int unsigned MEM_LATENCY      = 1,
   parameter int unsigned DEPTH            = 4,
   parameter logic [LEN_MEM_ADDR-1:0] RESET_PC = '0
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        redirect,
   input  logic [LEN_MEM_ADDR-1:0]     redirect_pc,
   output logic                        inst_valid,
   input  logic                        inst_ready,
   output logic [LEN_INST-1:0]         inst,
   output logic [LEN_MEM_ADDR-1:0]     inst_pc,
   output logic [LEN_MEMISTR_ADDR-1:0] a_inst_mem,
   output logic                        mem_en,
   input  logic [LEN_INST-1:0]         d_inst_mem
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned IW = $clog2(MEM_LATENCY + 1);

   logic [LEN_MEM_ADDR-1:0] fetch_pc_q, fetch_pc_d;
   logic [MEM_LATENCY-1:0]  stg_valid_q;
   logic [LEN_MEM_ADDR-1:0] stg_pc_q [MEM_LATENCY];
   logic [LEN_INST-1:0]     q_inst [DEPTH];
   logic [LEN_MEM_ADDR-1:0] q_pc [DEPTH];
   logic [PW-1:0]           rd_q, wr_q;
   logic [CW-1:0]           count_q, count_d;
   logic [IW-1:0]           inflight;
   logic                    issue, wr_en, pop;
   logic                    unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + IW'(stg_valid_q[i]);
      end
   end

   // Credit counts queued plus in-flight entries so a returning word always has a slot.
   assign issue      = ~redirect & ((32'(count_q) + 32'(inflight)) < DEPTH);
   assign mem_en     = issue;
   assign a_inst_mem = fetch_pc_q[LEN_MEMISTR_ADDR+1:2];
   assign wr_en      = stg_valid_q[MEM_LATENCY-1] & ~redirect;
   assign inst_valid = (count_q != '0) & ~redirect;
   assign pop        = inst_valid & inst_ready;
   assign inst       = q_inst[rd_q];
   assign inst_pc    = q_pc[rd_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[LEN_MEM_ADDR-1:2], 2'b00};
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + LEN_MEM_ADDR'(4);
         end
         count_d = count_q + CW'(wr_en) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_q  <= RESET_PC;
         stg_valid_q <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         count_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         if (redirect) begin
            stg_valid_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
         end else begin
            stg_valid_q[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) begin
               stg_valid_q[i] <= stg_valid_q[i-1];
            end
            if (wr_en) begin
               wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
               rd_q <= rd_q + PW'(1);
            end
         end
      end
   end

   // Payload storage is qualified by the valid bits and count, so it carries no reset.
   always_ff @(posedge clk) begin
      stg_pc_q[0] <= fetch_pc_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         stg_pc_q[i] <= stg_pc_q[i-1];
      end
      if (wr_en) begin
         q_inst[wr_q] <= d_inst_mem;
         q_pc[wr_q]   <= stg_pc_q[MEM_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random bench for fetch_queue: latency 1 / depth 4 and latency 3 / depth 8.
// The memory model returns the requested word address as the instruction.
module tb_fetch_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic        rstn_a, redirect_a, inst_ready_a, inst_valid_a, mem_en_a;
   logic [31:0] redirect_pc_a, inst_pc_a, inst_a, d_a;
   logic [14:0] addr_a, pipe_a;

   logic        rstn_b, redirect_b, inst_ready_b, inst_valid_b, mem_en_b;
   logic [31:0] redirect_pc_b, inst_pc_b, inst_b, d_b;
   logic [14:0] addr_b;
   logic [14:0] pipe_b [3];

   always @(posedge clk) begin
      pipe_a    <= addr_a;
      pipe_b[0] <= addr_b;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign d_a = {17'd0, pipe_a};
   assign d_b = {17'd0, pipe_b[2]};

   fetch_queue dut (
      .clk(clk), .rstn(rstn_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
      .inst_valid(inst_valid_a), .inst_ready(inst_ready_a), .inst(inst_a), .inst_pc(inst_pc_a),
      .a_inst_mem(addr_a), .mem_en(mem_en_a), .d_inst_mem(d_a)
   );

   fetch_queue #(.MEM_LATENCY(3), .DEPTH(8)) dut3 (
      .clk(clk), .rstn(rstn_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
      .inst_valid(inst_valid_b), .inst_ready(inst_ready_b), .inst(inst_b), .inst_pc(inst_pc_b),
      .a_inst_mem(addr_b), .mem_en(mem_en_b), .d_inst_mem(d_b)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the start of cycle 0 after reset release.
   task automatic reset_a();
      rstn_a = 1'b0;
      next_cycle();
      rstn_a = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (inst_valid_a !== 1'b0 || inst_valid_b !== 1'b0) begin
         $display("FAIL reset_valid: got a=%b b=%b, expected 0 0", inst_valid_a, inst_valid_b);
      end else n_pass++;
      n_checks++;
      if (mem_en_a !== 1'b1 || addr_a !== 15'd0) begin
         $display("FAIL reset_fetch: got mem_en=%b addr=%h, expected 1 0", mem_en_a, addr_a);
      end else n_pass++;
   endtask

   task automatic test_cold_start();
      inst_ready_a = 1'b1;
      next_cycle();
      rstn_a = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            n_checks++;
            if (mem_en_a !== 1'b1 || addr_a !== 15'd0) begin
               $display("FAIL cold_first_issue: got mem_en=%b addr=%h, expected 1 0",
                        mem_en_a, addr_a);
            end else n_pass++;
         end
         n_checks++;
         if (k < 2) begin
            if (inst_valid_a !== 1'b0) begin
               $display("FAIL cold_empty k=%0d: got valid=%b, expected 0", k, inst_valid_a);
            end else n_pass++;
         end else if (inst_valid_a !== 1'b1 || inst_pc_a !== 32'(4 * (k - 2)) ||
                      inst_a !== 32'(k - 2)) begin
            $display("FAIL cold_stream k=%0d: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                     k, inst_valid_a, inst_pc_a, inst_a, 32'(4 * (k - 2)), 32'(k - 2));
         end else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] exp_pc;
      int pops;
      inst_ready_a = 1'b0;
      reset_a();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_checks++;
         if (mem_en_a !== (k < 4)) begin
            $display("FAIL bp_mem_en k=%0d: got %b, expected %b", k, mem_en_a, k < 4);
         end else n_pass++;
         if (k >= 2) begin
            n_checks++;
            if (inst_valid_a !== 1'b1 || inst_pc_a !== 32'd0) begin
               $display("FAIL bp_head k=%0d: got valid=%b pc=%h, expected 1 0",
                        k, inst_valid_a, inst_pc_a);
            end else n_pass++;
         end
         next_cycle();
      end
      inst_ready_a = 1'b1;
      exp_pc = 32'd0;
      pops = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (inst_valid_a) begin
            n_checks++;
            if (inst_pc_a !== exp_pc) begin
               $display("FAIL bp_release: got pc=%h, expected %h", inst_pc_a, exp_pc);
            end else n_pass++;
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         next_cycle();
      end
      n_checks++;
      if (pops != 12) begin
         $display("FAIL bp_throughput: got %0d pops, expected 12", pops);
      end else n_pass++;
   endtask

   task automatic test_redirect();
      inst_ready_a = 1'b0;
      reset_a();
      // Cycle 4: three entries queued, pc 0xc in flight.
      for (int k = 0; k < 4; k++) next_cycle();
      redirect_a    = 1'b1;
      redirect_pc_a = 32'h0000_0100;
      @(negedge clk);
      n_checks++;
      if (inst_valid_a !== 1'b0 || mem_en_a !== 1'b0) begin
         $display("FAIL redir_cycle: got valid=%b mem_en=%b, expected 0 0",
                  inst_valid_a, mem_en_a);
      end else n_pass++;
      next_cycle();
      redirect_a = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_en_a !== 1'b1 || addr_a !== 15'h40 || inst_valid_a !== 1'b0) begin
         $display("FAIL redir_restart: got mem_en=%b addr=%h valid=%b, expected 1 40 0",
                  mem_en_a, addr_a, inst_valid_a);
      end else n_pass++;
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (inst_valid_a !== 1'b0) begin
         $display("FAIL redir_stale: got valid=%b, expected 0", inst_valid_a);
      end else n_pass++;
      next_cycle();
      inst_ready_a = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (inst_valid_a !== 1'b1 || inst_pc_a !== 32'h100 + 32'(4 * k) ||
             inst_a !== 32'h40 + 32'(k)) begin
            $display("FAIL redir_first k=%0d: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                     k, inst_valid_a, inst_pc_a, inst_a, 32'h100 + 32'(4 * k), 32'h40 + 32'(k));
         end else n_pass++;
         next_cycle();
      end
      // Two back-to-back redirects; the second (with ignored low bits) wins.
      redirect_a    = 1'b1;
      redirect_pc_a = 32'h0000_0200;
      @(negedge clk);
      n_checks++;
      if (inst_valid_a !== 1'b0) begin
         $display("FAIL b2b_valid: got %b, expected 0", inst_valid_a);
      end else n_pass++;
      next_cycle();
      redirect_pc_a = 32'h0000_0302;
      next_cycle();
      redirect_a = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_en_a !== 1'b1 || addr_a !== 15'hc0) begin
         $display("FAIL b2b_restart: got mem_en=%b addr=%h, expected 1 c0", mem_en_a, addr_a);
      end else n_pass++;
      next_cycle();
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (inst_valid_a !== 1'b1 || inst_pc_a !== 32'h300) begin
         $display("FAIL b2b_first: got valid=%b pc=%h, expected 1 300", inst_valid_a, inst_pc_a);
      end else n_pass++;
      next_cycle();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      inst_ready_a  = 1'b1;
      redirect_a    = 1'b1;
      redirect_pc_a = 32'hffff_fff9;
      next_cycle();
      redirect_a = 1'b0;
      @(negedge clk);
      n_checks++;
      if (addr_a !== 15'h7ffe) begin
         $display("FAIL wrap_addr: got %h, expected 7ffe", addr_a);
      end else n_pass++;
      next_cycle();
      next_cycle();
      exp_pc = 32'hffff_fff8;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (inst_valid_a !== 1'b1 || inst_pc_a !== exp_pc || inst_a !== {17'd0, exp_pc[16:2]}) begin
            $display("FAIL wrap_stream k=%0d: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                     k, inst_valid_a, inst_pc_a, inst_a, exp_pc, {17'd0, exp_pc[16:2]});
         end else n_pass++;
         exp_pc = exp_pc + 32'd4;
         next_cycle();
      end
   endtask

   task automatic test_latency3();
      inst_ready_b = 1'b1;
      rstn_b = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 0) begin
            n_checks++;
            if (mem_en_b !== 1'b1 || addr_b !== 15'd0) begin
               $display("FAIL l3_issue: got mem_en=%b addr=%h, expected 1 0", mem_en_b, addr_b);
            end else n_pass++;
         end
         n_checks++;
         if (k < 4) begin
            if (inst_valid_b !== 1'b0) begin
               $display("FAIL l3_empty k=%0d: got valid=%b, expected 0", k, inst_valid_b);
            end else n_pass++;
         end else if (inst_valid_b !== 1'b1 || inst_pc_b !== 32'(4 * (k - 4)) ||
                      inst_b !== 32'(k - 4)) begin
            $display("FAIL l3_stream k=%0d: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                     k, inst_valid_b, inst_pc_b, inst_b, 32'(4 * (k - 4)), 32'(k - 4));
         end else n_pass++;
         next_cycle();
      end
      redirect_b    = 1'b1;
      redirect_pc_b = 32'h0000_0400;
      next_cycle();
      redirect_b = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (k < 4) begin
            if (inst_valid_b !== 1'b0 || (k == 0 && (mem_en_b !== 1'b1 || addr_b !== 15'h100))) begin
               $display("FAIL l3_redir k=%0d: got valid=%b mem_en=%b addr=%h, expected 0 (1 100)",
                        k, inst_valid_b, mem_en_b, addr_b);
            end else n_pass++;
         end else if (inst_valid_b !== 1'b1 || inst_pc_b !== 32'h400 + 32'(4 * (k - 4))) begin
            $display("FAIL l3_redir_stream k=%0d: got valid=%b pc=%h, expected 1 %h",
                     k, inst_valid_b, inst_pc_b, 32'h400 + 32'(4 * (k - 4)));
         end else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_async_reset();
      inst_ready_a = 1'b1;
      reset_a();
      for (int k = 0; k < 5; k++) next_cycle();
      n_checks++;
      if (inst_valid_a !== 1'b1) begin
         $display("FAIL async_pre: got valid=%b, expected 1", inst_valid_a);
      end else n_pass++;
      #3;
      rstn_a = 1'b0;
      #1;
      n_checks++;
      if (inst_valid_a !== 1'b0 || mem_en_a !== 1'b1 || addr_a !== 15'd0) begin
         $display("FAIL async_clear: got valid=%b mem_en=%b addr=%h, expected 0 1 0",
                  inst_valid_a, mem_en_a, addr_a);
      end else n_pass++;
      next_cycle();
      rstn_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (k < 2) begin
            if (inst_valid_a !== 1'b0) begin
               $display("FAIL async_empty k=%0d: got valid=%b, expected 0", k, inst_valid_a);
            end else n_pass++;
         end else if (inst_valid_a !== 1'b1 || inst_pc_a !== 32'(4 * (k - 2))) begin
            $display("FAIL async_restart k=%0d: got valid=%b pc=%h, expected 1 %h",
                     k, inst_valid_a, inst_pc_a, 32'(4 * (k - 2)));
         end else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      int pops, ovf;
      reset_a();
      exp_pc = 32'd0;
      pops = 0;
      ovf = 0;
      for (int c = 0; c < 10000; c++) begin
         inst_ready_a  = ($urandom_range(0, 9) < 7);
         redirect_a    = ($urandom_range(0, 99) < 3);
         redirect_pc_a = ($urandom_range(0, 3) == 0) ? 32'hffff_ffe0 | 32'($urandom_range(0, 31))
                                                     : $urandom;
         @(negedge clk);
         if (dut.count_q > 3'd4) ovf++;
         if (redirect_a) begin
            n_checks++;
            if (inst_valid_a !== 1'b0) begin
               $display("FAIL rnd_redirect c=%0d: got valid=%b, expected 0", c, inst_valid_a);
            end else n_pass++;
            exp_pc = {redirect_pc_a[31:2], 2'b00};
         end else if (inst_valid_a && inst_ready_a) begin
            n_checks++;
            if (inst_pc_a !== exp_pc || inst_a !== {17'd0, exp_pc[16:2]}) begin
               $display("FAIL rnd_seq c=%0d: got pc=%h inst=%h, expected %h %h",
                        c, inst_pc_a, inst_a, exp_pc, {17'd0, exp_pc[16:2]});
            end else n_pass++;
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         next_cycle();
      end
      redirect_a = 1'b0;
      n_checks++;
      if (ovf != 0) begin
         $display("FAIL rnd_overflow: got %0d over-full cycles, expected 0", ovf);
      end else n_pass++;
      n_checks++;
      if (pops < 3000) begin
         $display("FAIL rnd_progress: got %0d pops, expected at least 3000", pops);
      end else n_pass++;
   endtask

   initial begin
      rstn_a = 1'b0; redirect_a = 1'b0; inst_ready_a = 1'b0; redirect_pc_a = '0;
      rstn_b = 1'b0; redirect_b = 1'b0; inst_ready_b = 1'b0; redirect_pc_b = '0;
      test_reset();
      test_cold_start();
      test_back_pressure();
      test_redirect();
      test_wrap();
      test_latency3();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter LEN_MEM_ADDR, default 32: byte-address width of pc.
REQ-002 SHALL have parameter LEN_INST, default 32: instruction width.
REQ-003 SHALL have parameter LEN_MEMISTR_ADDR, default 15: word-address width of instruction memory.
REQ-004 SHALL have parameter MEM_LATENCY, default 1: cycles from address to data, legal 1..4.
REQ-005 SHALL have parameter DEPTH, default 4: queue entries, power of two, legal 2..16.
REQ-006 SHALL have parameter RESET_PC, default 0: first fetch byte address.
REQ-007 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-008 rstn  in  1  asynchronous active-low reset.
REQ-009 redirect  in  1  flush and restart fetch at redirect_pc.
REQ-010 redirect_pc  in  LEN_MEM_ADDR  new fetch byte address, bits [1:0] ignored.
REQ-011 inst_valid  out  1  queue head holds a valid instruction.
REQ-012 inst_ready  in  1  consumer accepts head this cycle.
REQ-013 inst  out  LEN_INST  head instruction.
REQ-014 inst_pc  out  LEN_MEM_ADDR  byte address of head instruction.
REQ-015 a_inst_mem  out  LEN_MEMISTR_ADDR  word address = fetch_pc[LEN_MEMISTR_ADDR+1:2].
REQ-016 mem_en  out  1  a_inst_mem is a live request this cycle.
REQ-017 d_inst_mem  in  LEN_INST  memory data, valid MEM_LATENCY cycles after its mem_en.

Function
REQ-018 SHALL hold fetch_pc, a DEPTH-entry circular queue (inst, pc), rd/wr pointers, occupancy count, and an in-flight pipeline of MEM_LATENCY stages (valid, pc).
REQ-019 Issue rule: mem_en = ~redirect & (count + inflight < DEPTH); inflight = valid stages in pipeline; no credit taken for a same-cycle pop.
REQ-020 On issue, fetch_pc SHALL advance by 4 at the clock edge; otherwise it holds.
REQ-021 Issued request SHALL enter stage 1 with its pc; stages shift each cycle; stage MEM_LATENCY valid SHALL write d_inst_mem and that pc into queue entry wr at the edge ending that cycle.
REQ-022 Written entry SHALL be visible on inst_valid/inst/inst_pc the next cycle (issue-to-visible = MEM_LATENCY+1 cycles).
REQ-023 inst_valid = (count != 0) & ~redirect; inst/inst_pc SHALL show entry rd, don't-care when inst_valid=0.
REQ-024 Pop occurs when inst_valid & inst_ready; rd advances by 1 mod DEPTH.
REQ-025 Simultaneous write and pop: count unchanged, both pointers advance; write into full queue SHALL never occur (guaranteed by REQ-019, assertion in bench).
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0; count width SHALL hold 0..DEPTH inclusive.
REQ-027 redirect SHALL have priority: at the edge, count:=0, rd:=wr:=0, all in-flight valid bits cleared, fetch_pc := {redirect_pc[LEN_MEM_ADDR-1:2],2'b00}; no issue, write or pop in that cycle.
REQ-028 Data returning after a redirect for pre-redirect requests SHALL be discarded (in-flight valids already cleared).
REQ-029 Back-to-back redirects: the last one wins; first issue at the cycle after the final redirect.
REQ-030 With inst_ready held high and DEPTH >= MEM_LATENCY+2, SHALL sustain one instruction per cycle after fill.
REQ-031 fetch_pc SHALL wrap modulo 2^LEN_MEM_ADDR; a_inst_mem wraps with its truncated bits.

Reset
REQ-032 rstn low SHALL immediately clear count, pointers, in-flight valids, and set fetch_pc := RESET_PC, independent of clk.
REQ-033 During and right after reset: inst_valid=0; mem_en=1 in the first cycle after release (a_inst_mem=RESET_PC>>2).
REQ-034 Reset asserted mid-operation SHALL discard queued and in-flight instructions; fetch restarts at RESET_PC.
REQ-035 Queue data storage SHALL need no reset.

Verification
REQ-036 Cold start, MEM_LATENCY=1, DEPTH=4, inst_ready=1, mem returns word addr as data -> inst_valid first high cycle 2, inst_pc 0,4,8,12... one per cycle, no gaps.
REQ-037 Back-pressure: inst_ready=0 for 10 cycles -> count stops at 4, mem_en=0 once count+inflight=4, head stays inst_pc=0; release -> pcs continue 0,4,8 without loss or duplicate.
REQ-038 Redirect to 0x100 while 3 queued, 1 in flight -> inst_valid=0 in redirect cycle; stale return discarded; next cycle a_inst_mem=0x40; first delivered inst_pc=0x100.
REQ-039 MEM_LATENCY=3, DEPTH=8 -> first inst_valid 4 cycles after first issue; steady one/cycle; redirect with 3 in flight delivers none of them.
REQ-040 Async reset pulse between clock edges mid-stream -> outputs clear immediately; after release first inst_pc=RESET_PC.
REQ-041 Random inst_ready/redirect 10k cycles vs reference model -> inst_pc sequence matches, no overflow assertion fires, pointers wrap correctly.
